mel_filterbank: RTL and testbench

- Consumes the FFT power stream (power_valid/ptr/sample plus fft_done) and accumulates each power bin into triangular mel filters.
- Every bin contributes to at most two adjacent filters, lower and upper, through a per-bin table entry.
- Once the frame is complete, it drains one energy value per filter, in filter order, to the downstream log/DCT stage.

---
 rtl/mfcc_pkg.sv | 67 ++++++
 rtl/mel_filterbank_weight_mul.sv | 67 ++++++
 rtl/mel_filterbank.sv | 122 ++++++++++++
 tb/tb_mel_filterbank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared types, constants and helpers for the MFCC front end (mel filterbank and log stage).
package mfcc_pkg;

  localparam int NFFT         = 512;
  localparam int NFFT_LOG2    = $clog2(NFFT);
  localparam int NUM_BINS     = NFFT / 2;
  localparam int NUM_FILTERS  = 40;
  localparam int FILT_W       = $clog2(NUM_FILTERS);
  localparam int POWER_WIDTH  = 32;
  localparam int ACC_WIDTH    = 48;
  localparam int OUT_WIDTH    = 32;
  localparam int MEL_W_ONE    = 65536;
  localparam int FLUSH_CYCLES = 3;

  typedef struct packed {
    logic              hi_en;
    logic              lo_en;
    logic [FILT_W-1:0] idx;
    logic [15:0]       w;
  } mel_entry_t;

  typedef mel_entry_t [NUM_BINS-1:0] mel_rom_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } mel_state_e;

  // Mel-spaced band edges in bins (16 kHz, 512-point FFT); filter m spans edges m..m+2.
  localparam int MEL_EDGE [NUM_FILTERS+2] = '{
    0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 19, 22, 24, 27, 31, 34, 37, 41, 45, 50, 54,
    59, 64, 70, 76, 82, 88, 95, 103, 111, 119, 128, 138, 148, 159, 171, 183, 196,
    210, 224, 240, 256
  };

  function automatic logic [OUT_WIDTH-1:0] sat_trunc(input logic [ACC_WIDTH-1:0] acc);
    if (|acc[ACC_WIDTH-1:OUT_WIDTH]) return '1;
    return acc[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [POWER_WIDTH-1:0] x);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, acc} + (ACC_WIDTH+1)'(x);
    if (s[ACC_WIDTH]) return '1;
    return s[ACC_WIDTH-1:0];
  endfunction

  // Bin k in [edge j, edge j+1) is on the falling slope of filter j-1 and rising slope of filter j.
  function automatic mel_rom_t mel_default_rom();
    mel_rom_t rom;
    rom = '0;
    for (int j = 1; j <= NUM_FILTERS; j++) begin
      for (int k = MEL_EDGE[j]; k < MEL_EDGE[j+1]; k++) begin
        rom[k].lo_en = 1'b1;
        rom[k].hi_en = (j < NUM_FILTERS);
        rom[k].idx   = FILT_W'(j - 1);
        rom[k].w     = 16'(((k - MEL_EDGE[j]) * MEL_W_ONE) / (MEL_EDGE[j+1] - MEL_EDGE[j]));
      end
    end
    return rom;
  endfunction

endpackage

// File: rtl/mel_filterbank_weight_mul.sv
// Table lookup (S1) and dual weight multiply (S2): two-cycle latency, one bin per cycle.
module mel_weight_mul
  import mfcc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [NFFT_LOG2-2:0]   in_bin,
  input  logic [POWER_WIDTH-1:0] in_power,
  output logic                   out_valid,
  output logic                   out_lo_en,
  output logic                   out_hi_en,
  output logic [FILT_W-1:0]      out_idx,
  output logic [POWER_WIDTH-1:0] out_lo,
  output logic [POWER_WIDTH-1:0] out_hi
);

  mel_rom_t mel_rom = mel_default_rom();

  logic                   s1_valid;
  mel_entry_t             s1_entry;
  logic [POWER_WIDTH-1:0] s1_power;
  logic [16:0]            lo_w;

  assign lo_w = 17'(MEL_W_ONE) - {1'b0, s1_entry.w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
      s1_power <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_entry <= mel_rom[in_bin];
        s1_power <= in_power;
      end
    end
  end

  // 49-bit products, truncated after the Q0.16 shift; the upper filter is dropped past the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lo_en <= 1'b0;
      out_hi_en <= 1'b0;
      out_idx   <= '0;
      out_lo    <= '0;
      out_hi    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_lo_en <= s1_entry.lo_en;
        out_hi_en <= s1_entry.hi_en && (s1_entry.idx < FILT_W'(NUM_FILTERS - 1));
        out_idx   <= s1_entry.idx;
        out_lo    <= POWER_WIDTH'(({17'd0, s1_power} * {32'd0, lo_w}) >> 16);
        out_hi    <= POWER_WIDTH'(({17'd0, s1_power} * {33'd0, s1_entry.w}) >> 16);
      end
    end
  end

endmodule

// File: rtl/mel_filterbank.sv
// Mel filterbank: accumulates FFT power bins into triangular filters, then drains one energy per filter.
module mel_filterbank
  import mfcc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   power_valid_i,
  input  logic [NFFT_LOG2-1:0]   power_ptr_i,
  input  logic [POWER_WIDTH-1:0] power_sample_i,
  input  logic                   fft_done_i,
  output logic                   mel_valid_o,
  output logic [FILT_W-1:0]      mel_idx_o,
  output logic [OUT_WIDTH-1:0]   mel_energy_o,
  output logic                   mel_done_o,
  output logic                   busy_o
);

  mel_state_e             state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_FILTERS];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_FILTERS];
  logic                   clear_acc;
  logic                   take;
  logic                   p_valid, p_lo_en, p_hi_en;
  logic [FILT_W-1:0]      p_idx;
  logic [POWER_WIDTH-1:0] p_lo, p_hi;

  // A restart also discards whatever is still in the multiply pipeline.
  assign clear_acc = start_i && (state_q == ST_IDLE || state_q == ST_ACCUM);
  assign take      = (state_q == ST_ACCUM) && !start_i && power_valid_i
                     && !power_ptr_i[NFFT_LOG2-1];

  mel_weight_mul u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear_acc),
    .in_valid  (take),
    .in_bin    (power_ptr_i[NFFT_LOG2-2:0]),
    .in_power  (power_sample_i),
    .out_valid (p_valid),
    .out_lo_en (p_lo_en),
    .out_hi_en (p_hi_en),
    .out_idx   (p_idx),
    .out_lo    (p_lo),
    .out_hi    (p_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (!start_i && fft_done_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FILT_W'(FLUSH_CYCLES - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == FILT_W'(NUM_FILTERS - 1)) state_d = ST_DONE;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each sample touches two distinct filters, so at most one addend reaches any accumulator.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      acc_d[f] = acc_q[f];
      if (clear_acc) begin
        acc_d[f] = '0;
      end else if (p_valid) begin
        if (p_lo_en && p_idx == FILT_W'(f))
          acc_d[f] = sat_add(acc_q[f], p_lo);
        else if (p_hi_en && p_idx == FILT_W'(f - 1))
          acc_d[f] = sat_add(acc_q[f], p_hi);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FILTERS; f++) acc_q[f] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    mel_valid_o  = (state_q == ST_DRAIN);
    mel_idx_o    = '0;
    mel_energy_o = '0;
    if (mel_valid_o) begin
      mel_idx_o    = cnt_q;
      mel_energy_o = sat_trunc(acc_q[cnt_q]);
    end
    mel_done_o = (state_q == ST_DONE);
    busy_o     = (state_q == ST_ACCUM) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  end

endmodule

// File: tb/tb_mel_filterbank.sv
// Self-checking bench for mel_filterbank: directed frames with random tables/power against a filter-sum model.
module tb_mel_filterbank;

  localparam int NB = 256;
  localparam int NF = 40;
  localparam longint unsigned ACC_MAX = 64'h0000_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        power_valid_i = 1'b0;
  logic [8:0]  power_ptr_i = '0;
  logic [31:0] power_sample_i = '0;
  logic        fft_done_i = 1'b0;
  logic        mel_valid_o;
  logic [5:0]  mel_idx_o;
  logic [31:0] mel_energy_o;
  logic        mel_done_o;
  logic        busy_o;

  always #5 clk = ~clk;

  mel_filterbank dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .power_valid_i  (power_valid_i),
    .power_ptr_i    (power_ptr_i),
    .power_sample_i (power_sample_i),
    .fft_done_i     (fft_done_i),
    .mel_valid_o    (mel_valid_o),
    .mel_idx_o      (mel_idx_o),
    .mel_energy_o   (mel_energy_o),
    .mel_done_o     (mel_done_o),
    .busy_o         (busy_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic        hi_t  [NB];
  logic        lo_t  [NB];
  logic [5:0]  idx_t [NB];
  logic [15:0] w_t   [NB];
  longint unsigned acc_m [NF];
  logic [31:0] exp_q[$];
  int              s_ptr[$];
  longint unsigned s_pow[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put_entry(input int b, input logic h, input logic l, input int i, input int w);
    hi_t[b]  = h;
    lo_t[b]  = l;
    idx_t[b] = 6'(i);
    w_t[b]   = 16'(w);
    dut.u_mul.mel_rom[b] = {h, l, 6'(i), 16'(w)};
  endtask

  task automatic random_table();
    for (int b = 0; b < NB; b++)
      put_entry(b, 1'($urandom), 1'($urandom), $urandom_range(0, NF - 1), $urandom_range(0, 65535));
  endtask

  // Reference: every accepted bin adds p*(1-w) to filter idx and p*w to filter idx+1, saturating.
  task automatic model_clear();
    for (int f = 0; f < NF; f++) acc_m[f] = 0;
  endtask

  task automatic model_add(input int f, input longint unsigned v);
    longint unsigned s;
    s = acc_m[f] + v;
    acc_m[f] = (s > ACC_MAX) ? ACC_MAX : s;
  endtask

  task automatic model_sample(input int p, input longint unsigned pw);
    longint unsigned lo, hi;
    int i;
    if (p >= NB) return;
    lo = (pw * (65536 - longint'(w_t[p]))) >> 16;
    hi = (pw * longint'(w_t[p])) >> 16;
    i  = int'(idx_t[p]);
    if (lo_t[p]) model_add(i, lo);
    if (hi_t[p] && i + 1 < NF) model_add(i + 1, hi);
  endtask

  task automatic send_frame(input int restart_at, input bit done_with_last, input bit gaps);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    model_clear();
    chk("busy_accum", busy_o, 1);
    foreach (s_ptr[i]) begin
      if (i == restart_at) begin
        power_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        model_clear();
      end
      if (gaps && $urandom_range(0, 4) == 0) begin
        power_valid_i = 1'b0;
        tick();
      end
      power_valid_i  = 1'b1;
      power_ptr_i    = 9'(s_ptr[i]);
      power_sample_i = 32'(s_pow[i]);
      fft_done_i     = done_with_last && (i == s_ptr.size() - 1);
      tick();
      model_sample(s_ptr[i], s_pow[i]);
    end
    power_valid_i = 1'b0;
    if (!fft_done_i) begin
      fft_done_i = 1'b1;
      tick();
    end
    fft_done_i = 1'b0;
    for (int f = 0; f < NF; f++)
      exp_q.push_back((acc_m[f] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(acc_m[f]));
  endtask

  // Entered one cycle after fft_done_i was sampled; ignored inputs are driven while waiting.
  task automatic check_drain(input string tag, input int start_at, input int reset_at);
    int cyc;
    logic [31:0] e;
    cyc = 1;
    chk({tag, "_busy_flush"}, busy_o, 1);
    while (mel_valid_o !== 1'b1 && cyc < 12) begin
      power_valid_i  = 1'b1;
      power_ptr_i    = 9'($urandom_range(0, 255));
      power_sample_i = $urandom;
      tick();
      cyc++;
    end
    power_valid_i = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd4);
    if (cyc >= 12) begin
      exp_q.delete();
      return;
    end
    for (int k = 0; k < NF; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_valid%0d", tag, k), mel_valid_o, 1);
      chk($sformatf("%s_idx%0d", tag, k), mel_idx_o, 64'(k));
      chk($sformatf("%s_energy%0d", tag, k), mel_energy_o, e);
      chk($sformatf("%s_nodone%0d", tag, k), mel_done_o, 0);
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, mel_valid_o, 0);
        chk({tag, "_rst_done"}, mel_done_o, 0);
        chk({tag, "_rst_energy"}, mel_energy_o, 0);
        chk({tag, "_rst_busy"}, busy_o, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      start_i = (k == start_at);
      tick();
      start_i = 1'b0;
    end
    chk({tag, "_done"}, mel_done_o, 1);
    chk({tag, "_done_valid"}, mel_valid_o, 0);
    tick();
    chk({tag, "_done_pulse"}, mel_done_o, 0);
    chk({tag, "_idle_busy"}, busy_o, 0);
  endtask

  task automatic fill_samples(input int n, input int ptr_max, input bit in_order, input bit big);
    s_ptr.delete();
    s_pow.delete();
    for (int i = 0; i < n; i++) begin
      s_ptr.push_back(in_order ? i : $urandom_range(0, ptr_max));
      s_pow.push_back(big ? longint'($urandom) : longint'($urandom_range(0, 65535)));
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", mel_valid_o, 0);
    chk("rst_idx", mel_idx_o, 0);
    chk("rst_energy", mel_energy_o, 0);
    chk("rst_done", mel_done_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    tick();

    // fft_done_i and samples in IDLE are ignored
    fft_done_i    = 1'b1;
    power_valid_i = 1'b1;
    tick();
    fft_done_i    = 1'b0;
    power_valid_i = 1'b0;
    chk("idle_done_busy", busy_o, 0);
    chk("idle_done_valid", mel_valid_o, 0);

    // single bin: 0x10000 split 3/4 to filter 3, 1/4 to filter 4
    for (int b = 0; b < NB; b++) put_entry(b, 1'b0, 1'b0, 0, 0);
    put_entry(10, 1'b1, 1'b1, 3, 'h4000);
    s_ptr = '{10};
    s_pow = '{64'h10000};
    send_frame(-1, 1'b0, 1'b0);
    check_drain("single", -1, -1);

    // full frame back-to-back, last sample with fft_done_i
    random_table();
    fill_samples(NB, NB - 1, 1'b1, 1'b1);
    send_frame(-1, 1'b1, 1'b0);
    check_drain("full", -1, -1);

    // random order with gaps and out-of-range pointers
    for (int r = 0; r < 2; r++) begin
      random_table();
      fill_samples(120, 511, 1'b0, 1'b1);
      send_frame(-1, r[0], 1'b1);
      check_drain($sformatf("rand%0d", r), -1, -1);
    end

    // saturation: all bins into filter 5 at full weight
    for (int b = 0; b < NB; b++) put_entry(b, 1'b0, 1'b1, 5, 0);
    s_ptr.delete();
    s_pow.delete();
    for (int i = 0; i < NB; i++) begin
      s_ptr.push_back(i);
      s_pow.push_back(64'hFFFF_FFFF);
    end
    send_frame(-1, 1'b0, 1'b0);
    check_drain("sat", -1, -1);

    // last filter with hi_en set, plus ignored pointers >= 256
    for (int b = 0; b < NB; b++) put_entry(b, 1'b1, 1'b1, NF - 1, $urandom_range(0, 65535));
    fill_samples(80, 511, 1'b0, 1'b1);
    s_ptr.push_back(256);
    s_pow.push_back(64'hFFFF_FFFF);
    send_frame(-1, 1'b0, 1'b1);
    check_drain("edge39", -1, -1);

    // restart mid-ACCUM discards earlier samples
    random_table();
    fill_samples(40, NB - 1, 1'b0, 1'b1);
    send_frame(17, 1'b0, 1'b0);
    check_drain("restart", -1, -1);

    // start_i during DRAIN is ignored
    fill_samples(60, NB - 1, 1'b0, 1'b1);
    send_frame(-1, 1'b0, 1'b1);
    check_drain("start_drain", 10, -1);

    // reset mid-drain, then a clean frame
    fill_samples(60, NB - 1, 1'b0, 1'b1);
    send_frame(-1, 1'b0, 1'b0);
    check_drain("rst_drain", -1, 20);
    chk("post_rst_busy", busy_o, 0);
    fill_samples(90, 511, 1'b0, 1'b1);
    send_frame(-1, 1'b1, 1'b1);
    check_drain("post_rst", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
